// File: rtl/led_sw_ctrl_pkg.sv
// Shared mode encoding and decode helper for the LED/switch controller.
// Optional feature macro: LED_SW_DEBOUNCE_EN (see led_sw_ctrl.sv).
package led_sw_ctrl_pkg;

  localparam logic [1:0] MODE_OFF_ENC   = 2'b00;
  localparam logic [1:0] MODE_BLINK_ENC = 2'b01;
  localparam logic [1:0] MODE_SHIFT_ENC = 2'b10;
  localparam logic [1:0] MODE_COUNT_ENC = 2'b11;

  typedef enum logic [1:0] {
    MODE_OFF   = MODE_OFF_ENC,
    MODE_BLINK = MODE_BLINK_ENC,
    MODE_SHIFT = MODE_SHIFT_ENC,
    MODE_COUNT = MODE_COUNT_ENC
  } mode_t;

  // Highest switch wins: bit2 COUNT, bit1 SHIFT, bit0 BLINK.
  function automatic mode_t decode_mode(input logic [2:0] s);
    mode_t m;
    if (s[2])      m = MODE_COUNT;
    else if (s[1]) m = MODE_SHIFT;
    else if (s[0]) m = MODE_BLINK;
    else           m = MODE_OFF;
    return m;
  endfunction

endpackage

// File: rtl/led_sw_ctrl_sw_sync.sv
// Two-flop switch synchronizer, width-agnostic, with an optional stability
// filter enabled by LED_SW_DEBOUNCE_EN.
module sw_sync #(
  parameter int W               = 3,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;

  always_ff @(posedge clk) begin
    if (resetn) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

`ifdef LED_SW_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // Load value chosen so acceptance lands exactly DEBOUNCE_CYCLES after s2 settles.
  localparam logic [CW-1:0] LOAD = CW'(DEBOUNCE_CYCLES - 2);

  logic [W-1:0]  last;
  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (resetn) begin
      last <= '0;
      acc  <= '0;
      cnt  <= '0;
    end else if (s2 != last) begin
      last <= s2;
      cnt  <= LOAD;
    end else if (cnt == '0) begin
      acc <= last;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  assign q = acc;
`else
  assign q = s2;
`endif

endmodule

// File: rtl/led_sw_ctrl.sv
// LED animation controller: synchronized switches pick OFF/BLINK/SHIFT/COUNT,
// animation steps on a prescaler tick. LED_SW_DEBOUNCE_EN adds switch debounce.
//
// state (mode_q) | meaning
// MODE_OFF       | all LEDs dark
// MODE_BLINK     | all LEDs toggle every tick
// MODE_SHIFT     | single lit LED rotates left every tick
// MODE_COUNT     | LEDs show a binary counter incremented every tick
module led_sw_ctrl
  import led_sw_ctrl_pkg::*;
#(
  parameter int LED_NUM         = 4,
  parameter int SW_NUM          = 3,
  parameter int TICK_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [SW_NUM-1:0]  sw,
  output logic [LED_NUM-1:0] led
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TC = PW'(TICK_DIV - 1);

  logic [2:0]         sw_s;
  logic [PW-1:0]      cnt;
  logic [PW-1:0]      cnt_d;
  logic [LED_NUM-1:0] led_d;
  logic               tick;
  logic               changed;
  mode_t              mode_q;
  mode_t              mode_d;

  sw_sync #(
    .W               (3),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (sw[2:0]),
    .q      (sw_s)
  );

  always_ff @(posedge clk) begin
    if (resetn) begin
      led    <= '0;
      cnt    <= '0;
      mode_q <= MODE_OFF;
    end else begin
      led    <= led_d;
      cnt    <= cnt_d;
      mode_q <= mode_d;
    end
  end

  always_comb begin
    mode_d  = decode_mode(sw_s);
    changed = (mode_d != mode_q);
    tick    = (cnt == TC);
    led_d   = led;
    cnt_d   = tick ? '0 : cnt + PW'(1);
    // A mode change beats a coincident tick and restarts the prescaler.
    if (changed) begin
      cnt_d = '0;
      case (mode_d)
        MODE_BLINK: led_d = '1;
        MODE_SHIFT: led_d = LED_NUM'(1);
        default:    led_d = '0;
      endcase
    end else begin
      case (mode_q)
        MODE_OFF:   led_d = '0;
        MODE_BLINK: if (tick) led_d = ~led;
        MODE_SHIFT: if (tick) led_d = {led[LED_NUM-2:0], led[LED_NUM-1]};
        MODE_COUNT: if (tick) led_d = led + LED_NUM'(1);
        default:    led_d = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_led_sw_ctrl.sv
// Self-checking bench for led_sw_ctrl: expected LED values per clock edge are
// queued when stimulus is applied and compared as the edges occur.
module tb_led_sw_ctrl;

  localparam int LED_NUM = 4;
  localparam int SW_NUM  = 3;
`ifdef LED_SW_DEBOUNCE_EN
  localparam int EXTRA = 8;
`else
  localparam int EXTRA = 0;
`endif
  localparam int PRE = 2 + EXTRA;

  logic               clk;
  logic               resetn;
  logic [SW_NUM-1:0]  sw;
  logic [LED_NUM-1:0] led;

  logic [LED_NUM-1:0] exp_q[$];
  logic [LED_NUM-1:0] e;
  int total = 0;
  int bad   = 0;
  int idx;

  led_sw_ctrl #(
    .LED_NUM         (LED_NUM),
    .SW_NUM          (SW_NUM),
    .TICK_DIV        (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .sw     (sw),
    .led    (led)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  task automatic push_n(input logic [LED_NUM-1:0] v, input int n);
    repeat (n) exp_q.push_back(v);
  endtask

  // Reset for two edges with sw already at v; returns just after release.
  task automatic apply_reset(input logic [SW_NUM-1:0] v);
    resetn = 1'b1;
    sw     = v;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    sw     = 3'b000;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++;
      if (led !== 4'b0000) begin
        bad++;
        $display("FAIL reset_hold edge%0d got=%b want=0000", i, led);
      end
    end
    resetn = 1'b0;
    push_n(4'b0000, 6);
    idx = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (led !== e) begin
        bad++;
        $display("FAIL reset_release edge%0d got=%b want=%b", idx, led, e);
      end
      idx++;
    end
  endtask

  task automatic test_blink();
    apply_reset(3'b001);
    push_n(4'b0000, PRE);
    for (int k = 0; k < 4; k++) push_n((k % 2 == 0) ? 4'b1111 : 4'b0000, 4);
    idx = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (led !== e) begin
        bad++;
        $display("FAIL blink edge%0d got=%b want=%b", idx, led, e);
      end
      idx++;
    end
  endtask

  task automatic test_shift();
    apply_reset(3'b010);
    push_n(4'b0000, PRE);
    push_n(4'b0001, 4);
    push_n(4'b0010, 4);
    push_n(4'b0100, 4);
    push_n(4'b1000, 4);
    push_n(4'b0001, 4);
    idx = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (led !== e) begin
        bad++;
        $display("FAIL shift edge%0d got=%b want=%b", idx, led, e);
      end
      idx++;
    end
  endtask

  task automatic test_count();
    apply_reset(3'b100);
    push_n(4'b0000, PRE);
    for (int k = 0; k < 16; k++) push_n(4'(k), 4);
    push_n(4'b0000, 4);
    push_n(4'b0001, 1);
    idx = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (led !== e) begin
        bad++;
        $display("FAIL count edge%0d got=%b want=%b", idx, led, e);
      end
      idx++;
    end
  endtask

  task automatic test_priority();
    apply_reset(3'b011);
    push_n(4'b0000, PRE);
    push_n(4'b0001, 4);
    push_n(4'b0010, 1);
    idx = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (led !== e) begin
        bad++;
        $display("FAIL prio_shift edge%0d got=%b want=%b", idx, led, e);
      end
      idx++;
    end
    sw = 3'b000;
    repeat (PRE) @(posedge clk);
    push_n(4'b0000, 5);
    idx = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (led !== e) begin
        bad++;
        $display("FAIL prio_clear edge%0d got=%b want=%b", idx, led, e);
      end
      idx++;
    end
    sw = 3'b110;
    push_n(4'b0000, PRE + 4);
    push_n(4'b0001, 4);
    push_n(4'b0010, 1);
    idx = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (led !== e) begin
        bad++;
        $display("FAIL prio_count edge%0d got=%b want=%b", idx, led, e);
      end
      idx++;
    end
  endtask

  task automatic test_reset_mid();
    apply_reset(3'b010);
    push_n(4'b0000, PRE);
    push_n(4'b0001, 4);
    push_n(4'b0010, 4);
    push_n(4'b0100, 1);
    idx = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (led !== e) begin
        bad++;
        $display("FAIL mid_run edge%0d got=%b want=%b", idx, led, e);
      end
      idx++;
    end
    resetn = 1'b1;
    @(posedge clk); #1;
    total++;
    if (led !== 4'b0000) begin
      bad++;
      $display("FAIL mid_reset got=%b want=0000", led);
    end
    resetn = 1'b0;
    push_n(4'b0000, PRE);
    push_n(4'b0001, 4);
    push_n(4'b0010, 1);
    idx = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (led !== e) begin
        bad++;
        $display("FAIL mid_restart edge%0d got=%b want=%b", idx, led, e);
      end
      idx++;
    end
  endtask

  // sw bounces BLINK -> SHIFT before the synchronizer samples; only SHIFT counts.
  task automatic test_settle();
    apply_reset(3'b000);
    repeat (PRE + 2) @(posedge clk);
    #1;
    sw = 3'b001;
    #2;
    sw = 3'b010;
    push_n(4'b0000, PRE);
    push_n(4'b0001, 4);
    push_n(4'b0010, 1);
    idx = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (led !== e) begin
        bad++;
        $display("FAIL settle edge%0d got=%b want=%b", idx, led, e);
      end
      idx++;
    end
  endtask

`ifdef LED_SW_DEBOUNCE_EN
  task automatic test_glitch();
    apply_reset(3'b010);
    push_n(4'b0000, PRE);
    push_n(4'b0001, 1);
    idx = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (led !== e) begin
        bad++;
        $display("FAIL glitch_pre edge%0d got=%b want=%b", idx, led, e);
      end
      idx++;
    end
    sw = 3'b100;
    @(posedge clk); #1;
    sw = 3'b010;
    push_n(4'b0001, 2);
    push_n(4'b0010, 4);
    push_n(4'b0100, 4);
    push_n(4'b1000, 4);
    idx = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (led !== e) begin
        bad++;
        $display("FAIL glitch edge%0d got=%b want=%b", idx, led, e);
      end
      idx++;
    end
  endtask
`endif

  initial begin
    resetn = 1'b1;
    sw     = '0;
    @(negedge clk);
    test_reset();
    test_blink();
    test_shift();
    test_count();
    test_priority();
    test_reset_mid();
    test_settle();
`ifdef LED_SW_DEBOUNCE_EN
    test_glitch();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
